difference_map_engine: RTL

- Sequential, parametrised successor to the single-shot combinational difference-map opcode.
- Owns a DEPTH-word register file and executes commands of the form dst[i] = f(dst[i], src[i]) for i < len.
- Processes LANES words per clock over arbitrary lengths, with a selectable arithmetic mode.
- Sits beside the execution stage as a multi-cycle coprocessor. The host loads and reads words through a side port and issues commands through a valid/ready handshake.

---
 rtl/difference_map_engine.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/difference_map_engine.sv
// Multi-cycle difference-map coprocessor: dst[i] = f(dst[i], src[i]) over a DEPTH-word file, LANES words per cycle.
// Optional signed saturation with sticky sat_flag is enabled by defining DIFFMAP_SAT_EN.
module difference_map_engine #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int LANES = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [AW-1:0]    cmd_src,
    input  logic [AW:0]      cmd_len,
    input  logic [1:0]       cmd_mode,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [WIDTH-1:0] host_wdata,
    output logic [WIDTH-1:0] host_rdata,
    output logic             busy,
    output logic             done,
    output logic             sat_flag
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] off_q, off_d;
    logic [AW:0]   rem_q, rem_d;
    logic [1:0]    mode_q, mode_d;

    logic [AW-1:0]    lane_dst [LANES];
    logic [AW-1:0]    lane_src [LANES];
    logic [WIDTH-1:0] lane_res [LANES];
    logic             lane_act [LANES];

`ifdef DIFFMAP_SAT_EN
    logic lane_sat [LANES];
    logic sat_q, sat_d;

    // Returns {saturated, result}; the difference is formed one bit wider so overflow is visible.
    function automatic logic [WIDTH:0] lane_op(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [1:0]       mode);
        logic [WIDTH:0]   wide;
        logic [WIDTH:0]   mag;
        logic [WIDTH-1:0] res;
        logic             sat;
        if (mode == 2'd1) begin
            wide = {b[WIDTH-1], b} - {a[WIDTH-1], a};
        end else begin
            wide = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        end
        sat = 1'b0;
        res = wide[WIDTH-1:0];
        if (mode == 2'd2) begin
            mag = wide[WIDTH] ? -wide : wide;
            if (mag[WIDTH] || mag[WIDTH-1]) begin
                sat = 1'b1;
                res = {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                res = mag[WIDTH-1:0];
            end
        end else if (wide[WIDTH] != wide[WIDTH-1]) begin
            sat = 1'b1;
            res = wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return {sat, res};
    endfunction
`else
    // Wrapping arithmetic; ABSDIFF takes the magnitude of the already-wrapped difference.
    function automatic logic [WIDTH-1:0] lane_op(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0]       mode);
        logic [WIDTH-1:0] diff;
        diff = (mode == 2'd1) ? (b - a) : (a - b);
        if (mode == 2'd2 && diff[WIDTH-1]) begin
            diff = -diff;
        end
        return diff;
    endfunction
`endif

    // Every lane reads the start-of-cycle snapshot mem_q, so overlapping chunks behave deterministically.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_dst[i] = dst_q + off_q + AW'(i);
            lane_src[i] = src_q + off_q + AW'(i);
            lane_act[i] = ((AW+1)'(i) < rem_q);
`ifdef DIFFMAP_SAT_EN
            {lane_sat[i], lane_res[i]} = lane_op(mem_q[lane_dst[i]], mem_q[lane_src[i]], mode_q);
`else
            lane_res[i] = lane_op(mem_q[lane_dst[i]], mem_q[lane_src[i]], mode_q);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
        src_d   = src_q;
        off_d   = off_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        mem_d   = mem_q;

        if (host_we && state_q != RUN) begin
            mem_d[host_addr] = host_wdata;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dst_d   = cmd_dst;
                    src_d   = cmd_src;
                    rem_d   = cmd_len;
                    mode_d  = cmd_mode;
                    off_d   = '0;
                    state_d = (cmd_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < LANES; i++) begin
                    if (lane_act[i]) begin
                        mem_d[lane_dst[i]] = lane_res[i];
                    end
                end
                off_d = off_q + AW'(LANES);
                if (rem_q <= (AW+1)'(LANES)) begin
                    rem_d   = '0;
                    state_d = DONE;
                end else begin
                    rem_d = rem_q - (AW+1)'(LANES);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dst_q   <= '0;
            src_q   <= '0;
            off_q   <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            off_q   <= off_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            mem_q   <= mem_d;
        end
    end

`ifdef DIFFMAP_SAT_EN
    // Sticky until the next accepted command clears it.
    always_comb begin
        sat_d = sat_q;
        if (state_q == IDLE && cmd_valid) begin
            sat_d = 1'b0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_act[i] && lane_sat[i]) begin
                    sat_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    assign sat_flag = 1'b0;
`endif

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign host_rdata = mem_q[host_addr];

endmodule
